down_timer8: RTL and testbench

- Loadable 8-bit down-counter/timer; the count-down counterpart of the up-counter with carry-out used for OTDR timebase counting.
- Consumes count strobes (typically the up-counter's carry `C` or a sample-clock enable) and expires after a programmed number of strobes.
- Emits a cascadable borrow pulse `B` and done/busy status.
- Sits in the acquisition control path; gates record windows and dead-time intervals.

---
 rtl/down_timer_pkg.sv | 14 +
 rtl/down_timer8.sv | 88 ++++++++
 tb/tb_down_timer8.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the loadable down-timer.
// State encoding: IDLE/RUN/DONE; code 3 is illegal and recovers to IDLE.
package down_timer_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ILL  = 2'd3
    } dt_state_t;

endpackage

// File: rtl/down_timer8.sv
// Loadable down-counter/timer; expires after counter+1 en strobes, pulses B.
// Latency: state/counter registered (1 cycle); B is combinational in the terminal cycle.
// No backpressure: every en strobe in RUN is consumed. DOWN_TIMER_AUTORELOAD_EN selects auto-reload.
module down_timer8
    import down_timer_pkg::*;
#(
    parameter int              WIDTH       = DT_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RELOAD_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] counter,
    output logic             B,
    output logic             busy,
    output logic             done
);

    dt_state_t        state_q, state_d;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] reload_reg, reload_d;
    logic             cnt_zero;

    assign cnt_zero = (counter == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = counter;
        reload_d = reload_reg;
        if (clr) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end else if (load) begin
            cnt_d    = load_val;
            reload_d = load_val;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = cnt_zero ? ST_DONE : ST_RUN;
                end
                ST_DONE: begin
                    if (start) begin
                        cnt_d   = reload_reg;
                        state_d = (reload_reg != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        if (!cnt_zero) begin
                            cnt_d = counter - 1'b1;
                        end else begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
                            cnt_d = reload_reg;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Terminal pulse; qualified by rst_n so a reset cycle never cascades a borrow.
    assign B = (state_q == ST_RUN) && cnt_zero && en && !clr && !load && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            counter    <= '0;
            reload_reg <= RELOAD_INIT;
        end else begin
            state_q    <= state_d;
            counter    <= cnt_d;
            reload_reg <= reload_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_down_timer8.sv
// Directed bench for down_timer8 with hand-computed expectations.
module tb_down_timer8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       en;
    logic       clr;
    logic [7:0] counter;
    logic       B;
    logic       busy;
    logic       done;

    int   checks = 0;
    int   errors = 0;
    logic b_s;

    down_timer8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .en       (en),
        .clr      (clr),
        .counter  (counter),
        .B        (B),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle; B is sampled mid-cycle, outputs just after the edge.
    task automatic step(input logic l, input logic [7:0] lv, input logic s,
                        input logic e, input logic c);
        load = l; load_val = lv; start = s; en = e; clr = c;
        @(negedge clk);
        b_s = B;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [7:0] c, input logic bz, input logic dn);
        chk({tag, ".counter"}, 32'(counter), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    initial begin
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        chk_st("reset", 0, 0, 0);
        chk("reset.B", 32'(b_s), 0);
        rst_n = 1'b1;

        // Reset mid-RUN
        step(1, 5, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_st("pre_rst", 3, 1, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 1, 0);
        chk_st("mid_rst", 0, 0, 0);
        chk("mid_rst.B", 32'(b_s), 0);
        rst_n = 1'b1;
        step(0, 0, 0, 1, 0);
        chk_st("post_rst", 0, 0, 0);

        // Reset in the terminal cycle suppresses B
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk_st("term_pre", 0, 1, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 1, 0);
        chk("term_rst.B", 32'(b_s), 0);
        chk_st("term_rst", 0, 0, 0);
        rst_n = 1'b1;

        // Priority: clr > load > en, then load beats start
        step(1, 4, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk_st("prio_pre", 2, 1, 0);
        step(1, 9, 0, 1, 1);
        chk("prio_clr.B", 32'(b_s), 0);
        chk_st("prio_clr", 0, 0, 0);
        step(1, 7, 1, 0, 0);
        chk_st("prio_ld", 7, 0, 0);
        step(0, 0, 0, 1, 0);
        chk_st("prio_idle_en", 7, 0, 0);

`ifndef DOWN_TIMER_AUTORELOAD_EN
        // Basic count, then restart from DONE
        step(1, 3, 0, 0, 0);
        chk_st("basic_ld", 3, 0, 0);
        for (int r = 0; r < 2; r++) begin
            step(0, 0, 1, 0, 0);
            chk_st("basic_start", 3, 1, 0);
            for (int i = 0; i < 4; i++) begin
                step(0, 0, 0, 1, 0);
                chk("basic.B", 32'(b_s), (i == 3) ? 1 : 0);
                chk("basic.counter", 32'(counter), (i < 3) ? 32'(2 - i) : 0);
            end
            chk_st("basic_done", 0, 0, 1);
            step(0, 0, 0, 1, 0);
            chk("done_en.B", 32'(b_s), 0);
            chk_st("done_en", 0, 0, 1);
        end

        // Zero load: start goes straight to DONE without B
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("zero.B", 32'(b_s), 0);
        chk_st("zero_done", 0, 0, 1);
        step(0, 0, 1, 1, 0);
        chk("zero_restart.B", 32'(b_s), 0);
        chk_st("zero_restart", 0, 0, 1);

        // clr keeps the reload register
        step(1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk_st("clr_pre", 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_st("clr_idle", 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_st("clr_idle_start", 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk_st("clr_reload", 2, 1, 0);

        // Gapped strobes
        step(1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        begin
            logic [5:0] pat;
            logic [7:0] exp_c [6];
            logic [5:0] exp_b;
            pat   = 6'b101001;
            exp_b = 6'b100000;
            exp_c = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
            for (int i = 0; i < 6; i++) begin
                step(0, 0, 0, pat[i], 0);
                chk("gap.B", 32'(b_s), 32'(exp_b[i]));
                chk("gap.counter", 32'(counter), 32'(exp_c[i]));
            end
        end
        chk_st("gap_done", 0, 0, 1);
`else
        // Auto-reload: B every third strobe, never DONE
        step(1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_st("ar_start", 2, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 1, 0);
            chk("ar.B", 32'(b_s), (k % 3 == 0) ? 1 : 0);
            chk_st("ar", (k % 3 == 0) ? 8'd2 : 8'(2 - (k % 3)), 1, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
